seven_seg_capture: RTL and testbench
====================================

Name: seven_seg_capture

Overview:
- Receiving end of the multiplexed seven-segment scan bus (`addr` digit select, `out` segment pattern) that the display driver produces.
- Samples the scan and filters glitches. Decodes each digit's segment pattern back to a 4-bit value and publishes a complete 6-digit frame.
- Used for on-board self-test and for scoreboard checking of the vending display in simulation.

Parameters:
- NUM_DIGITS, 6, number of scanned digits (width of addr).
- STABLE_CYCLES, 3, consecutive identical samples required to accept a digit (1..15).
- TIMEOUT_CYCLES, 4096, cycles without a completed frame before `stale` asserts.

Ports:
- clk  input  1  system clock, same domain as the scan source.
- reset  input  1  asynchronous, active-high reset.
- addr  input  6  digit select, active-high one-hot; bit i selects digit i; all-zero = blanking.
- seg  input  8  segment pattern, active-low; [6:0] = g,f,e,d,c,b,a; [7] = dp.
- digits  output  24  captured frame; digits[4i+3:4i] = digit i.
- dp  output  6  captured decimal-point state per digit (1 = lit).
- frame_valid  output  1  one-cycle pulse when `digits`/`dp` update.
- seg_err  output  1  one-cycle pulse when an accepted pattern is not a legal hex glyph.
- addr_err  output  1  one-cycle pulse on a multi-hot addr sample.
- stale  output  1  high when no frame has completed within TIMEOUT_CYCLES.

Behaviour:
- Reset (async, active-high) clears:
  - digits=0, dp=0, frame_valid=0, seg_err=0, addr_err=0.
  - Internal mask, counters and last-sample registers = 0; filter state = HUNT.
  - stale=1 while reset is high, and it stays 1 until the first frame completes.
- Input registering: addr/seg are registered once on input (1 cycle).
- Filter FSM, per registered sample:
  - HUNT: if addr is one-hot, load last_addr/last_seg, set cnt=1 and go to COUNT; otherwise stay in HUNT.
  - COUNT: if the sample equals last (addr and seg), cnt++. When cnt reaches STABLE_CYCLES, accept the digit and go to LOCKED. On a differing sample, restart as in HUNT using the new sample.
  - LOCKED: stay while the sample is unchanged. Any change (including blanking) goes to HUNT handling of the new sample in the same cycle. A digit is never accepted twice per lock.
- Multi-hot addr: addr_err pulses in the cycle after the registered sample; the FSM goes to HUNT. All-zero addr is a legal blank: no error, FSM goes to HUNT.
- Accept, for index i = position of the set bit:
  - Decode seg[6:0] via the glyph table (0-9, A-F).
  - Legal glyph: write the shadow nibble i and shadow dp i (= ~seg[7]), and set mask[i].
  - Illegal glyph: seg_err pulses, mask is cleared to 0, the shadow is untouched, and the frame restarts.
- Frame completion:
  - When mask becomes all-ones, copy the shadow to digits/dp next cycle, pulse frame_valid, clear mask, clear timeout counter and drop stale.
  - Latency from the accepting sample edge to frame_valid = 2 cycles.
  - A digit re-accepted before completion overwrites its shadow value (newest wins).
- Timeout:
  - The counter increments each cycle and saturates at TIMEOUT_CYCLES, at which point stale=1.
  - Only frame_valid clears the counter. digits hold their last values.
- Simultaneous events: a frame completion and a timeout saturation in the same cycle resolve to frame_valid=1, stale=0.
- Reset mid-frame discards all partial shadow data.

Decomposition:
- Shared package seven_seg_pkg:
  - NUM_DIGITS.
  - Active-low glyph constants: 0=0x40, 1=0x79, 2=0x24, 3=0x30, 4=0x19, 5=0x12, 6=0x02, 7=0x78, 8=0x00, 9=0x10, A=0x08, b=0x03, C=0x46, d=0x21, E=0x06, F=0x0E.
  - Filter state enum HUNT/COUNT/LOCKED.
- Sub-module seg7_decode: combinational 7-bit pattern in, 4-bit value and legal flag out. Shared with the driver's encoder table so both sides use one source.

Test Plan:
- Clean scan: digits 5..0 = 1,A,3,7,0,0 (seg 0xF9,0x88,0xB0,0xF8,0xC0,0xC0), each held 4 cycles with 1-cycle blank between. Required: frame_valid pulses once, digits=0x1A3700, dp=0, stale=0.
- Glitch: digit 2 shows 0xF9 for 2 cycles, then 0xB0 for 4 cycles (STABLE_CYCLES=3). Required: digit 2 captured as 3 and no error.
- Illegal glyph: seg=0xFF (blank pattern) held 4 cycles on addr=6'b000100. Required: seg_err pulses once, mask cleared, no frame_valid until 6 fresh legal digits arrive.
- Multi-hot: addr=6'b000011 for 5 cycles. Required: addr_err pulses each of those sample cycles and nothing is captured.
- Timeout: no scan for 4096 cycles after one good frame. Required: stale rises at cycle 4096 and digits keep the prior frame.
- Reset mid-frame: assert reset after 3 digits are accepted, then scan a full frame. Required: exactly one frame_valid, with only the new values.

Source files
------------

// File: rtl/seven_seg_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seven_seg_pkg
//  Purpose  : Shared constants for the seven-segment scan bus: digit count,
//             active-low glyph table (bit 0 = segment a) and filter states.
//  Revision : 1.0  initial release
// ============================================================================
package seven_seg_pkg;

    localparam int NUM_DIGITS = 6;

    // Active-low glyphs, [6:0] = g,f,e,d,c,b,a
    localparam logic [6:0] GLYPH_0 = 7'h40;
    localparam logic [6:0] GLYPH_1 = 7'h79;
    localparam logic [6:0] GLYPH_2 = 7'h24;
    localparam logic [6:0] GLYPH_3 = 7'h30;
    localparam logic [6:0] GLYPH_4 = 7'h19;
    localparam logic [6:0] GLYPH_5 = 7'h12;
    localparam logic [6:0] GLYPH_6 = 7'h02;
    localparam logic [6:0] GLYPH_7 = 7'h78;
    localparam logic [6:0] GLYPH_8 = 7'h00;
    localparam logic [6:0] GLYPH_9 = 7'h10;
    localparam logic [6:0] GLYPH_A = 7'h08;
    localparam logic [6:0] GLYPH_B = 7'h03;
    localparam logic [6:0] GLYPH_C = 7'h46;
    localparam logic [6:0] GLYPH_D = 7'h21;
    localparam logic [6:0] GLYPH_E = 7'h06;
    localparam logic [6:0] GLYPH_F = 7'h0E;

    // Glitch filter states
    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        COUNT  = 2'd1,
        LOCKED = 2'd2
    } filt_state_e;

endpackage : seven_seg_pkg
`default_nettype wire

// File: rtl/seg7_decode.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_decode
//  Purpose  : Combinational inverse of the display encoder table: maps an
//             active-low 7-bit segment pattern to its hex value and flags
//             patterns that are not one of the sixteen hex glyphs.
//  Revision : 1.0  initial release
// ============================================================================
module seg7_decode
    import seven_seg_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] value,
    output logic       legal
);

    // Glyph table lookup; anything outside the table is illegal
    always_comb begin
        value = 4'h0;
        legal = 1'b1;
        case (pattern)
            GLYPH_0: value = 4'h0;
            GLYPH_1: value = 4'h1;
            GLYPH_2: value = 4'h2;
            GLYPH_3: value = 4'h3;
            GLYPH_4: value = 4'h4;
            GLYPH_5: value = 4'h5;
            GLYPH_6: value = 4'h6;
            GLYPH_7: value = 4'h7;
            GLYPH_8: value = 4'h8;
            GLYPH_9: value = 4'h9;
            GLYPH_A: value = 4'hA;
            GLYPH_B: value = 4'hB;
            GLYPH_C: value = 4'hC;
            GLYPH_D: value = 4'hD;
            GLYPH_E: value = 4'hE;
            GLYPH_F: value = 4'hF;
            default: legal = 1'b0;
        endcase
    end

endmodule : seg7_decode
`default_nettype wire

// File: rtl/seven_seg_capture.sv
`default_nettype none
// ============================================================================
//  Module   : seven_seg_capture
//  Purpose  : Samples a multiplexed seven-segment scan bus, filters glitches,
//             decodes each digit and publishes complete frames. Flags illegal
//             glyphs, multi-hot digit selects and a stalled display.
//  Revision : 1.0  initial release
// ============================================================================
module seven_seg_capture #(
    parameter int NUM_DIGITS     = 6,
    parameter int STABLE_CYCLES  = 3,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_DIGITS-1:0]   addr,
    input  logic [7:0]              seg,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [NUM_DIGITS-1:0]   dp,
    output logic                    frame_valid,
    output logic                    seg_err,
    output logic                    addr_err,
    output logic                    stale
);
    import seven_seg_pkg::*;

    localparam int              TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [3:0]      STABLE_C = 4'(STABLE_CYCLES);
    localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_CYCLES);

    // Registered scan inputs
    logic [NUM_DIGITS-1:0]   addr_in_q;
    logic [7:0]              seg_in_q;

    // Filter FSM
    filt_state_e             state_q, state_d;
    logic [NUM_DIGITS-1:0]   last_addr_q, last_addr_d;
    logic [7:0]              last_seg_q, last_seg_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    accept;

    // Frame assembly
    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
    logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
    logic [NUM_DIGITS-1:0]   mask_q, mask_d;
    logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
    logic [NUM_DIGITS-1:0]   dp_q, dp_d;
    logic                    frame_valid_q, frame_valid_d;
    logic                    seg_err_q, seg_err_d;
    logic                    addr_err_q, addr_err_d;
    logic [TMO_W-1:0]        tmo_q, tmo_d;
    logic                    stale_q, stale_d;

    logic                    sample_onehot;
    logic                    sample_multi;
    logic                    sample_same;
    logic                    frame_done;
    logic [3:0]              dec_value;
    logic                    dec_legal;

    assign sample_onehot = (addr_in_q != '0) &&
                           ((addr_in_q & (addr_in_q - NUM_DIGITS'(1))) == '0);
    assign sample_multi  = (addr_in_q != '0) && !sample_onehot;
    assign sample_same   = (addr_in_q == last_addr_q) && (seg_in_q == last_seg_q);
    assign frame_done    = &mask_q;

    seg7_decode u_decode (
        .pattern (seg_in_q[6:0]),
        .value   (dec_value),
        .legal   (dec_legal)
    );

    // Input sampling register: one cycle of latency before filtering
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_in_q <= '0;
            seg_in_q  <= '0;
        end else begin
            addr_in_q <= addr;
            seg_in_q  <= seg;
        end
    end

    // Filter FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= HUNT;
            last_addr_q <= '0;
            last_seg_q  <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            last_addr_q <= last_addr_d;
            last_seg_q  <= last_seg_d;
            cnt_q       <= cnt_d;
        end
    end

    // Filter FSM next state: any change of sample restarts the hunt in place
    always_comb begin
        logic reload;
        state_d     = state_q;
        last_addr_d = last_addr_q;
        last_seg_d  = last_seg_q;
        cnt_d       = cnt_q;
        accept      = 1'b0;
        reload      = 1'b0;
        case (state_q)
            COUNT: begin
                if (sample_same) begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_d == STABLE_C) begin
                        accept  = 1'b1;
                        state_d = LOCKED;
                    end
                end else begin
                    reload = 1'b1;
                end
            end
            LOCKED: begin
                if (!sample_same) begin
                    reload = 1'b1;
                end
            end
            default: reload = 1'b1;
        endcase
        if (reload) begin
            if (sample_onehot) begin
                last_addr_d = addr_in_q;
                last_seg_d  = seg_in_q;
                cnt_d       = 4'd1;
                if (STABLE_C == 4'd1) begin
                    accept  = 1'b1;
                    state_d = LOCKED;
                end else begin
                    state_d = COUNT;
                end
            end else begin
                state_d = HUNT;
            end
        end
    end

    // Datapath outputs: shadow update, frame publication, errors, timeout
    always_comb begin
        shadow_d      = shadow_q;
        shadow_dp_d   = shadow_dp_q;
        mask_d        = frame_done ? '0 : mask_q;
        digits_d      = frame_done ? shadow_q : digits_q;
        dp_d          = frame_done ? shadow_dp_q : dp_q;
        frame_valid_d = frame_done;
        seg_err_d     = 1'b0;
        addr_err_d    = sample_multi;
        if (accept) begin
            if (dec_legal) begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (addr_in_q[i]) begin
                        shadow_d[4*i +: 4] = dec_value;
                        shadow_dp_d[i]     = ~seg_in_q[7];
                        mask_d[i]          = 1'b1;
                    end
                end
            end else begin
                seg_err_d = 1'b1;
                mask_d    = '0;
            end
        end
        // Completion wins over a simultaneous timeout saturation
        if (frame_done) begin
            tmo_d   = '0;
            stale_d = 1'b0;
        end else begin
            tmo_d   = (tmo_q == TMO_MAX) ? tmo_q : tmo_q + TMO_W'(1);
            stale_d = (tmo_d == TMO_MAX) ? 1'b1 : stale_q;
        end
    end

    // Frame, error and timeout registers; stale powers up asserted
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_q      <= '0;
            shadow_dp_q   <= '0;
            mask_q        <= '0;
            digits_q      <= '0;
            dp_q          <= '0;
            frame_valid_q <= 1'b0;
            seg_err_q     <= 1'b0;
            addr_err_q    <= 1'b0;
            tmo_q         <= '0;
            stale_q       <= 1'b1;
        end else begin
            shadow_q      <= shadow_d;
            shadow_dp_q   <= shadow_dp_d;
            mask_q        <= mask_d;
            digits_q      <= digits_d;
            dp_q          <= dp_d;
            frame_valid_q <= frame_valid_d;
            seg_err_q     <= seg_err_d;
            addr_err_q    <= addr_err_d;
            tmo_q         <= tmo_d;
            stale_q       <= stale_d;
        end
    end

    assign digits      = digits_q;
    assign dp          = dp_q;
    assign frame_valid = frame_valid_q;
    assign seg_err     = seg_err_q;
    assign addr_err    = addr_err_q;
    assign stale       = stale_q;

endmodule : seven_seg_capture
`default_nettype wire

// File: tb/tb_seven_seg_capture.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seven_seg_capture
//  Purpose  : Scoreboard bench for seven_seg_capture. Stimulus pushes expected
//             frames; a negedge monitor pops and compares on frame_valid.
//  Revision : 1.0  initial release
// ============================================================================
module tb_seven_seg_capture;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  addr;
    logic [7:0]  seg;
    logic [23:0] digits;
    logic [5:0]  dp;
    logic        frame_valid;
    logic        seg_err;
    logic        addr_err;
    logic        stale;

    always #5 clk = ~clk;

    seven_seg_capture #(
        .NUM_DIGITS     (6),
        .STABLE_CYCLES  (3),
        .TIMEOUT_CYCLES (4096)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .addr        (addr),
        .seg         (seg),
        .digits      (digits),
        .dp          (dp),
        .frame_valid (frame_valid),
        .seg_err     (seg_err),
        .addr_err    (addr_err),
        .stale       (stale)
    );

    typedef struct packed {
        logic [23:0] d;
        logic [5:0]  p;
    } frame_t;

    frame_t exp_q[$];
    int tests_run      = 0;
    int tests_failed   = 0;
    int n_frames       = 0;
    int n_seg_err      = 0;
    int n_addr_err     = 0;
    int cyc            = 0;
    int last_frame_cyc = 0;
    int stale_rise_cyc = -1;
    logic stale_prev   = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every published frame against the scoreboard head
    always @(negedge clk) begin
        frame_t e;
        if (!reset) begin
            if (frame_valid) begin
                n_frames++;
                last_frame_cyc = cyc;
                if (exp_q.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("FAIL unexpected_frame: got digits 0x%0h dp 0x%0h, required no frame", digits, dp);
                end else begin
                    e = exp_q.pop_front();
                    check("frame_digits", {8'h0, digits}, {8'h0, e.d});
                    check("frame_dp", {26'h0, dp}, {26'h0, e.p});
                end
            end
            if (seg_err)  n_seg_err++;
            if (addr_err) n_addr_err++;
            if (stale && !stale_prev && stale_rise_cyc < 0) stale_rise_cyc = cyc;
        end
        stale_prev = stale;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic show(input int idx, input logic [7:0] s, input int n);
        addr = 6'(1 << idx);
        seg  = s;
        tick(n);
    endtask

    task automatic blank(input int n);
        addr = 6'h00;
        seg  = 8'hFF;
        tick(n);
    endtask

    task automatic scan(input int idx, input logic [7:0] s);
        show(idx, s, 4);
        blank(1);
    endtask

    task automatic scan_frame(input logic [7:0] s5, s4, s3, s2, s1, s0);
        scan(5, s5); scan(4, s4); scan(3, s3);
        scan(2, s2); scan(1, s1); scan(0, s0);
    endtask

    initial begin
        reset = 1'b1;
        addr  = 6'h00;
        seg   = 8'hFF;
        tick(3);

        // Reset state
        check("rst_digits", {8'h0, digits}, 32'h0);
        check("rst_dp", {26'h0, dp}, 32'h0);
        check("rst_frame_valid", {31'h0, frame_valid}, 32'h0);
        check("rst_seg_err", {31'h0, seg_err}, 32'h0);
        check("rst_addr_err", {31'h0, addr_err}, 32'h0);
        check("rst_stale", {31'h0, stale}, 32'h1);
        reset = 1'b0;
        tick(2);
        check("stale_after_release", {31'h0, stale}, 32'h1);

        // Clean scan
        exp_q.push_back('{d: 24'h1A3700, p: 6'h00});
        scan_frame(8'hF9, 8'h88, 8'hB0, 8'hF8, 8'hC0, 8'hC0);
        tick(4);
        check("clean_frames", n_frames, 1);
        check("clean_stale", {31'h0, stale}, 32'h0);
        check("clean_errs", n_seg_err + n_addr_err, 0);

        // Glitch on digit 2 plus a lit dp on digit 0
        exp_q.push_back('{d: 24'h456380, p: 6'b000001});
        scan(5, 8'h99); scan(4, 8'h92); scan(3, 8'h82);
        show(2, 8'hF9, 2);
        show(2, 8'hB0, 4);
        blank(1);
        scan(1, 8'h80); scan(0, 8'h40);
        tick(4);
        check("glitch_frames", n_frames, 2);
        check("glitch_seg_err", n_seg_err, 0);

        // Illegal glyph clears the partial frame
        scan(5, 8'h99); scan(4, 8'h99); scan(3, 8'h99); scan(1, 8'h99); scan(0, 8'h99);
        show(2, 8'hFF, 4);
        blank(1);
        tick(3);
        check("illegal_seg_err", n_seg_err, 1);
        scan(2, 8'hA4);
        tick(4);
        check("illegal_no_frame", n_frames, 2);
        exp_q.push_back('{d: 24'hABCDEF, p: 6'h00});
        scan_frame(8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E);
        tick(4);
        check("fresh_frames", n_frames, 3);
        check("fresh_seg_err", n_seg_err, 1);

        // Multi-hot select
        addr = 6'b000011;
        seg  = 8'hC0;
        tick(5);
        blank(1);
        tick(3);
        check("multi_addr_err", n_addr_err, 5);
        check("multi_frames", n_frames, 3);
        check("multi_digits", {8'h0, digits}, 32'h00ABCDEF);

        // Timeout: bounded wait for stale to rise
        stale_rise_cyc = -1;
        for (int i = 0; i < 5000 && stale_rise_cyc < 0; i++) tick(1);
        if (stale_rise_cyc < 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL timeout_wait: stale never rose within 5000 cycles, required rise at 4096");
        end else begin
            check("timeout_cycles", stale_rise_cyc - last_frame_cyc, 4096);
        end
        check("timeout_digits", {8'h0, digits}, 32'h00ABCDEF);
        check("timeout_stale", {31'h0, stale}, 32'h1);

        // Reset mid-frame
        scan(5, 8'h99); scan(4, 8'h99); scan(3, 8'h99);
        reset = 1'b1;
        tick(2);
        check("midrst_digits", {8'h0, digits}, 32'h0);
        check("midrst_stale", {31'h0, stale}, 32'h1);
        reset = 1'b0;
        tick(2);
        exp_q.push_back('{d: 24'h123456, p: 6'h00});
        scan_frame(8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82);
        tick(4);
        check("midrst_frames", n_frames, 4);
        check("midrst_stale_low", {31'h0, stale}, 32'h0);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_seven_seg_capture
`default_nettype wire
